// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, RAM address, IF/ID register, IDLE/RUN/HALT FSM.
// Optional halt-on-instruction capture is enabled by defining FETCH_HALT_INSTR_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 4096,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_fetch_i,
    input  logic        halt_fetch_i,
    input  logic        stall_fetch_i,
    input  logic        redirect_en_fetch_i,
    input  logic [31:0] redirect_pc_fetch_i,
    input  logic [31:0] instr_imem_fetch_i,
    output logic [31:0] addr_imem_fetch_o,
    output logic [31:0] instr_fetch_o,
    output logic [31:0] pc_fetch_o,
    output logic [31:0] pc_plus4_fetch_o,
    output logic        valid_fetch_o,
    output logic        halted_fetch_o
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1);
`ifdef FETCH_HALT_INSTR_EN
    localparam logic HALT_INSTR_EN = 1'b1;
`else
    localparam logic HALT_INSTR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_inc;
    logic [31:0] redirect_pc;
    logic        is_halt_instr;

    assign pc_inc        = (pc_q + 32'd4) & PC_MASK;
    assign redirect_pc   = redirect_pc_fetch_i & PC_MASK & ~32'd3;
    assign is_halt_instr = HALT_INSTR_EN && (instr_imem_fetch_i == HALT_INSTR);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        if_pc_d  = if_pc_q;
        if_pc4_d = if_pc4_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (redirect_en_fetch_i) begin
                    pc_d = redirect_pc;
                end
                if (halt_fetch_i) begin
                    state_d = S_HALT;
                end else if (start_fetch_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_fetch_i) begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                end else if (redirect_en_fetch_i) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (!stall_fetch_i) begin
                    instr_d  = instr_imem_fetch_i;
                    if_pc_d  = pc_q;
                    if_pc4_d = pc_inc;
                    valid_d  = 1'b1;
                    // A halt instruction is delivered downstream but the PC parks on it.
                    if (is_halt_instr) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            if_pc_q  <= 32'd0;
            if_pc4_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            if_pc_q  <= if_pc_d;
            if_pc4_q <= if_pc4_d;
            valid_q  <= valid_d;
        end
    end

    assign addr_imem_fetch_o = pc_q;
    assign instr_fetch_o     = instr_q;
    assign pc_fetch_o        = if_pc_q;
    assign pc_plus4_fetch_o  = if_pc4_q;
    assign valid_fetch_o     = valid_q;
    assign halted_fetch_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a cycle-level reference model.
module tb_instr_fetch;

    localparam int IMEM = 4096;
`ifdef FETCH_HALT_INSTR_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_fetch_i, halt_fetch_i, stall_fetch_i, redirect_en_fetch_i;
    logic [31:0] redirect_pc_fetch_i, instr_imem_fetch_i;
    logic [31:0] addr_imem_fetch_o, instr_fetch_o, pc_fetch_o, pc_plus4_fetch_o;
    logic        valid_fetch_o, halted_fetch_o;

    logic [31:0] mem [0:IMEM/4-1];

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .start_fetch_i       (start_fetch_i),
        .halt_fetch_i        (halt_fetch_i),
        .stall_fetch_i       (stall_fetch_i),
        .redirect_en_fetch_i (redirect_en_fetch_i),
        .redirect_pc_fetch_i (redirect_pc_fetch_i),
        .instr_imem_fetch_i  (instr_imem_fetch_i),
        .addr_imem_fetch_o   (addr_imem_fetch_o),
        .instr_fetch_o       (instr_fetch_o),
        .pc_fetch_o          (pc_fetch_o),
        .pc_plus4_fetch_o    (pc_plus4_fetch_o),
        .valid_fetch_o       (valid_fetch_o),
        .halted_fetch_o      (halted_fetch_o)
    );

    always #5 clk = ~clk;

    assign instr_imem_fetch_i = mem[addr_imem_fetch_o[11:2]];

    // Reference model: mode 0=idle, 1=run, 2=halt.
    int unsigned m_pc;
    int          m_mode;
    logic [31:0] m_instr, m_pcout, m_pc4;
    logic        m_valid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 0; m_mode <= 0; m_instr <= 0; m_pcout <= 0; m_pc4 <= 0; m_valid <= 0;
        end else if (m_mode == 0) begin
            m_valid <= 0;
            if (redirect_en_fetch_i) m_pc <= ((redirect_pc_fetch_i % IMEM) / 4) * 4;
            if (halt_fetch_i) m_mode <= 2;
            else if (start_fetch_i) m_mode <= 1;
        end else if (m_mode == 1) begin
            if (halt_fetch_i) begin
                m_mode <= 2; m_valid <= 0;
            end else if (redirect_en_fetch_i) begin
                m_pc <= ((redirect_pc_fetch_i % IMEM) / 4) * 4; m_valid <= 0;
            end else if (!stall_fetch_i) begin
                m_instr <= mem[m_pc / 4];
                m_pcout <= m_pc;
                m_pc4   <= (m_pc + 4) % IMEM;
                m_valid <= 1;
                if (HALT_EN && mem[m_pc / 4] == 32'hFFFF_FFFF) m_mode <= 2;
                else m_pc <= (m_pc + 4) % IMEM;
            end
        end else begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (addr_imem_fetch_o !== m_pc || instr_fetch_o !== m_instr || pc_fetch_o !== m_pcout ||
                pc_plus4_fetch_o !== m_pc4 || valid_fetch_o !== m_valid ||
                halted_fetch_o !== (m_mode == 2)) begin
                bad++;
                $display("FAIL model_cmp t=%0t got addr=%h instr=%h pc=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc=%h pc4=%h v=%b h=%b",
                         $time, addr_imem_fetch_o, instr_fetch_o, pc_fetch_o, pc_plus4_fetch_o,
                         valid_fetch_o, halted_fetch_o, m_pc, m_instr, m_pcout, m_pc4, m_valid, m_mode == 2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        start_fetch_i = 0; halt_fetch_i = 0; stall_fetch_i = 0;
        redirect_en_fetch_i = 0; redirect_pc_fetch_i = 0;
    endtask

    initial begin
        for (int i = 0; i < IMEM / 4; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        clear_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_addr", addr_imem_fetch_o, 32'h0);
        chk("rst_instr", instr_fetch_o, 32'h0);
        chk("rst_pc4", pc_plus4_fetch_o, 32'h0);
        chk("rst_valid", {31'd0, valid_fetch_o}, 32'd0);
        chk("rst_halted", {31'd0, halted_fetch_o}, 32'd0);
        reset = 0;
        @(negedge clk);
        start_fetch_i = 1;
        @(negedge clk);
        start_fetch_i = 0;
        chk("start_addr", addr_imem_fetch_o, 32'h0);
        chk("start_valid", {31'd0, valid_fetch_o}, 32'd0);
        @(negedge clk);
        chk("f0_instr", instr_fetch_o, 32'h11);
        chk("f0_pc4", pc_plus4_fetch_o, 32'h4);
        chk("f0_valid", {31'd0, valid_fetch_o}, 32'd1);
        @(negedge clk);
        chk("f1_instr", instr_fetch_o, 32'h22);
        chk("f1_addr", addr_imem_fetch_o, 32'h8);
        @(negedge clk);
        chk("f2_instr", instr_fetch_o, 32'h33);
        chk("f2_pc", pc_fetch_o, 32'h8);
        stall_fetch_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr", instr_fetch_o, 32'h33);
            chk("stall_addr", addr_imem_fetch_o, 32'hC);
        end
        stall_fetch_i = 0;
        @(negedge clk);
        chk("resume_instr", instr_fetch_o, 32'hA000_0003);
        chk("resume_pc", pc_fetch_o, 32'hC);
        redirect_en_fetch_i = 1; redirect_pc_fetch_i = 32'h105; stall_fetch_i = 1;
        @(negedge clk);
        clear_inputs();
        chk("redir_addr", addr_imem_fetch_o, 32'h104);
        chk("redir_bubble", {31'd0, valid_fetch_o}, 32'd0);
        @(negedge clk);
        chk("redir_instr", instr_fetch_o, 32'hA000_0041);
        chk("redir_pc", pc_fetch_o, 32'h104);
        redirect_en_fetch_i = 1; redirect_pc_fetch_i = 32'h0000_7FFE;
        @(negedge clk);
        clear_inputs();
        chk("mask_addr", addr_imem_fetch_o, 32'hFFC);
        @(negedge clk);
        chk("wrap_pc", pc_fetch_o, 32'hFFC);
        chk("wrap_pc4", pc_plus4_fetch_o, 32'h0);
        chk("wrap_addr", addr_imem_fetch_o, 32'h0);
        @(negedge clk);
        chk("wrap_instr", instr_fetch_o, 32'h11);
        halt_fetch_i = 1;
        @(negedge clk);
        halt_fetch_i = 0;
        chk("halt_flag", {31'd0, halted_fetch_o}, 32'd1);
        chk("halt_valid", {31'd0, valid_fetch_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            start_fetch_i = i[0]; stall_fetch_i = i[1]; redirect_en_fetch_i = i[2] | i[0];
            redirect_pc_fetch_i = 32'h40;
            @(negedge clk);
            chk("halt_addr", addr_imem_fetch_o, 32'h4);
            chk("halt_hold", {30'd0, halted_fetch_o, valid_fetch_o}, 32'd2);
        end
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        start_fetch_i = 1;
        @(negedge clk);
        start_fetch_i = 0;
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("mid_rst_addr", addr_imem_fetch_o, 32'h0);
        chk("mid_rst_instr", instr_fetch_o, 32'h0);
        chk("mid_rst_pc", pc_fetch_o, 32'h0);
        chk("mid_rst_valid", {31'd0, valid_fetch_o}, 32'd0);
        @(negedge clk);
        reset = 0;
        redirect_en_fetch_i = 1; redirect_pc_fetch_i = 32'h203;
        @(negedge clk);
        clear_inputs();
        chk("boot_addr", addr_imem_fetch_o, 32'h200);
        @(negedge clk);
        chk("idle_addr", addr_imem_fetch_o, 32'h200);
        chk("idle_valid", {31'd0, valid_fetch_o}, 32'd0);
        #2 reset = 1;
        @(negedge clk);
        reset = 0;
        mem[2] = 32'hFFFF_FFFF;
        start_fetch_i = 1;
        @(negedge clk);
        start_fetch_i = 0;
        repeat (3) @(negedge clk);
        chk("hi_instr", instr_fetch_o, 32'hFFFF_FFFF);
        chk("hi_valid", {31'd0, valid_fetch_o}, 32'd1);
        chk("hi_pc", pc_fetch_o, 32'h8);
`ifdef FETCH_HALT_INSTR_EN
        chk("hi_addr", addr_imem_fetch_o, 32'h8);
        @(negedge clk);
        chk("hi_halted", {31'd0, halted_fetch_o}, 32'd1);
        chk("hi_drop", {31'd0, valid_fetch_o}, 32'd0);
        chk("hi_park", addr_imem_fetch_o, 32'h8);
`else
        chk("hi_addr", addr_imem_fetch_o, 32'hC);
        @(negedge clk);
        chk("hi_next", instr_fetch_o, 32'hA000_0003);
        chk("hi_halted", {31'd0, halted_fetch_o}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
